// File: rtl/sift_pkg.sv
// rtl/sift_pkg.sv - shared constants and types for the SIFT descriptor path
package sift_pkg;

    localparam int SIFT_DATA_W   = 8;
    localparam int SIFT_DESC_LEN = 128;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_DONE    = 2'd3
    } packer_state_t;

endpackage

// File: rtl/sift_sync_fifo.sv
// rtl/sift_sync_fifo.sv - show-ahead synchronous FIFO with simultaneous push/pop
module sift_sync_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  pop_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

    // A pop in the same cycle frees the slot a full FIFO would otherwise refuse.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    // Head is gated so an empty FIFO presents zeros rather than stale data.
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sift_desc_packer.sv
// rtl/sift_desc_packer.sv - packs SIFT descriptor bytes into framed words and signals frame completion
module sift_desc_packer
    import sift_pkg::*;
#(
    parameter int DATA_W     = SIFT_DATA_W,
    parameter int OUT_W      = 32,
    parameter int DESC_LEN   = SIFT_DESC_LEN,
    parameter int FIFO_DEPTH = 16,
    parameter int NUM_DONE   = 2
) (
    input  logic                clk_sys,
    input  logic                rst_sys,
    input  logic                in_valid,
    input  logic [DATA_W-1:0]   in_data,
    input  logic [NUM_DONE-1:0] done_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_W-1:0]    out_data,
    output logic                out_last,
    output logic [15:0]         desc_count,
    output logic                overflow,
    output logic                frame_done
);

    localparam int LANES   = OUT_W / DATA_W;
    localparam int LANE_W  = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int CNT_W   = (DESC_LEN > 1) ? $clog2(DESC_LEN) : 1;
    localparam int FIFO_AW = $clog2(FIFO_DEPTH);

    packer_state_t         state;
    packer_state_t         state_nxt;
    logic [OUT_W-1:0]      pack_data;
    logic [OUT_W-1:0]      word_cur;
    logic [LANE_W-1:0]     lane_idx;
    logic [CNT_W-1:0]      byte_cnt;
    logic [NUM_DONE-1:0]   done_prev;
    logic [NUM_DONE-1:0]   done_mask;
    logic [NUM_DONE-1:0]   done_rise;
    logic                  fill;
    logic                  flushing;
    logic                  push;
    logic                  push_last;
    logic                  pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [FIFO_AW:0]      fifo_count;
    logic [OUT_W:0]        fifo_dout;

    // Current word with this cycle's byte dropped into its lane; unfilled lanes stay zero.
    always_comb begin
        word_cur = pack_data;
        if (in_valid) begin
            for (int k = 0; k < LANES; k++) begin
                if (lane_idx == LANE_W'(k)) begin
                    word_cur[k*DATA_W +: DATA_W] = in_data;
                end
            end
        end
    end

    assign fill      = in_valid && (lane_idx == LANE_W'(LANES - 1));
    // In FLUSH any held bytes, including one arriving now, close out the frame.
    assign flushing  = (state == ST_FLUSH) && (in_valid || (lane_idx != '0));
    assign push      = fill || flushing;
    assign push_last = flushing || (byte_cnt == CNT_W'(DESC_LEN - 1));
    assign pop       = out_valid && out_ready;
    assign done_rise = done_in & ~done_prev;

    sift_sync_fifo #(
        .W     (OUT_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk_sys),
        .rst_n     (rst_sys),
        .push      (push),
        .push_data ({push_last, word_cur}),
        .pop       (pop),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign out_valid  = !fifo_empty;
    assign out_data   = fifo_dout[OUT_W-1:0];
    assign out_last   = fifo_dout[OUT_W];
    assign frame_done = (state == ST_DONE);

    always_ff @(posedge clk_sys or negedge rst_sys) begin
        if (!rst_sys) begin
            pack_data <= '0;
            lane_idx  <= '0;
            byte_cnt  <= '0;
        end else if (flushing) begin
            pack_data <= '0;
            lane_idx  <= '0;
            byte_cnt  <= '0;
        end else if (in_valid) begin
            byte_cnt <= (byte_cnt == CNT_W'(DESC_LEN - 1)) ? '0 : byte_cnt + CNT_W'(1);
            if (fill) begin
                pack_data <= '0;
                lane_idx  <= '0;
            end else begin
                pack_data <= word_cur;
                lane_idx  <= lane_idx + LANE_W'(1);
            end
        end
    end

    always_ff @(posedge clk_sys or negedge rst_sys) begin
        if (!rst_sys) begin
            state      <= ST_COLLECT;
            done_prev  <= '0;
            done_mask  <= '0;
            overflow   <= 1'b0;
            desc_count <= '0;
        end else begin
            state     <= state_nxt;
            done_prev <= done_in;
            if (state == ST_COLLECT) begin
                done_mask <= done_mask | done_rise;
            end else if (state == ST_DONE) begin
                done_mask <= '0;
            end
            // The word is lost but framing already advanced with the byte counter.
            if (push && fifo_full && !pop) begin
                overflow <= 1'b1;
            end
            if (pop && out_last && (desc_count != 16'hFFFF)) begin
                desc_count <= desc_count + 16'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_COLLECT: begin
                if (&done_mask) begin
                    state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if ((fifo_count == '0) && !push && !in_valid && (lane_idx == '0)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_COLLECT;
            end
            default: begin
                state_nxt = ST_COLLECT;
            end
        endcase
    end

endmodule
